// File: rtl/code_word_rx_if.sv
// Signal bundle between the serial code-word receiver and its surroundings:
// serial line and checker verdict in, held code word and statistics out.
interface code_word_rx_if #(
    parameter int CNT_W = 8
);
    logic             serial_in;
    logic             valid_in;
    logic             a;
    logic             b;
    logic             c;
    logic             d;
    logic             e;
    logic             f;
    logic             word_ready;
    logic             busy;
    logic             last_valid;
    logic [CNT_W-1:0] valid_count;
    logic [CNT_W-1:0] invalid_count;
    logic [1:0]       dbg_state;

    // No handshake back-pressure: word_ready is a one-cycle strobe in the last
    // CHECK cycle and valid_in must be settled when that cycle ends.
    modport master (
        output serial_in, valid_in,
        input  a, b, c, d, e, f, word_ready, busy, last_valid,
        input  valid_count, invalid_count, dbg_state
    );

    modport slave (
        input  serial_in, valid_in,
        output a, b, c, d, e, f, word_ready, busy, last_valid,
        output valid_count, invalid_count, dbg_state
    );
endinterface

// File: rtl/code_word_rx.sv
// Deserializes start-bit framed 6-bit code words, holds them on a..f for the
// external checker, then records the checker verdict in saturating counters.
module code_word_rx #(
    parameter int CNT_W      = 8,
    parameter int CHECK_WAIT = 1
) (
    input  logic           clock,
    input  logic           reset,
    code_word_rx_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } state_e;

    localparam logic [3:0]       WAIT_LAST = 4'(CHECK_WAIT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_e           state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [3:0]       wait_cnt_q, wait_cnt_d;
    logic [5:0]       shift_q, shift_d;
    logic [5:0]       word_q, word_d;
    logic             last_valid_q, last_valid_d;
    logic [CNT_W-1:0] vcnt_q, vcnt_d;
    logic [CNT_W-1:0] icnt_q, icnt_d;
    logic             check_last;

    assign check_last = (state_q == CHECK) && (wait_cnt_q == WAIT_LAST);

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        shift_d      = shift_q;
        word_d       = word_q;
        last_valid_d = last_valid_q;
        vcnt_d       = vcnt_q;
        icnt_d       = icnt_q;
        case (state_q)
            IDLE: begin
                if (bus.serial_in) begin
                    state_d   = SHIFT;
                    bit_cnt_d = 3'd0;
                end
            end
            SHIFT: begin
                // First data bit ends up in bit 5, which drives output a.
                shift_d = {shift_q[4:0], bus.serial_in};
                if (bit_cnt_q == 3'd5) begin
                    word_d     = {shift_q[4:0], bus.serial_in};
                    wait_cnt_d = 4'd0;
                    state_d    = CHECK;
                end else begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            CHECK: begin
                if (check_last) begin
                    last_valid_d = bus.valid_in;
                    if (bus.valid_in) begin
                        if (vcnt_q != CNT_MAX) vcnt_d = vcnt_q + CNT_ONE;
                    end else begin
                        if (icnt_q != CNT_MAX) icnt_d = icnt_q + CNT_ONE;
                    end
                    state_d = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            bit_cnt_q    <= 3'd0;
            wait_cnt_q   <= 4'd0;
            shift_q      <= 6'd0;
            word_q       <= 6'd0;
            last_valid_q <= 1'b0;
            vcnt_q       <= '0;
            icnt_q       <= '0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            shift_q      <= shift_d;
            word_q       <= word_d;
            last_valid_q <= last_valid_d;
            vcnt_q       <= vcnt_d;
            icnt_q       <= icnt_d;
        end
    end

    assign bus.a             = word_q[5];
    assign bus.b             = word_q[4];
    assign bus.c             = word_q[3];
    assign bus.d             = word_q[2];
    assign bus.e             = word_q[1];
    assign bus.f             = word_q[0];
    assign bus.word_ready    = check_last;
    assign bus.busy          = (state_q != IDLE);
    assign bus.last_valid    = last_valid_q;
    assign bus.valid_count   = vcnt_q;
    assign bus.invalid_count = icnt_q;
    assign bus.dbg_state     = state_q;
endmodule

// File: tb/tb_code_word_rx.sv
// Bench for code_word_rx: scoreboard of framed words against a counting model,
// plus a CHECK_WAIT=3 instance for verdict-sampling timing.
module tb_code_word_rx;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int EXP_W   = 6 + 1 + CNT_W + CNT_W;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  code_word_rx_if #(.CNT_W(CNT_W)) bus1 ();
  code_word_rx_if #(.CNT_W(CNT_W)) bus3 ();

  code_word_rx #(.CNT_W(CNT_W), .CHECK_WAIT(1)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1.slave)
  );

  code_word_rx #(.CNT_W(CNT_W), .CHECK_WAIT(3)) dut3 (
    .clock (clock),
    .reset (reset),
    .bus   (bus3.slave)
  );

  // expected entry: {word a..f, verdict, valid_count, invalid_count}
  logic [EXP_W-1:0] exp_q[$];
  int m_vcnt;
  int m_icnt;
  int n_checks = 0;
  int n_fail = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endfunction

  function automatic logic [5:0] word1();
    return {bus1.a, bus1.b, bus1.c, bus1.d, bus1.e, bus1.f};
  endfunction

  function automatic logic [5:0] word3();
    return {bus3.a, bus3.b, bus3.c, bus3.d, bus3.e, bus3.f};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus1.serial_in = 1'b0;
    bus3.serial_in = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    m_vcnt = 0;
    m_icnt = 0;
    exp_q.delete();
  endtask

  // Reference: each completed frame bumps exactly one saturating count.
  task automatic send_frame(input logic [5:0] word, input logic verdict, input int check_ticks);
    if (verdict) m_vcnt = (m_vcnt < CNT_MAX) ? m_vcnt + 1 : CNT_MAX;
    else         m_icnt = (m_icnt < CNT_MAX) ? m_icnt + 1 : CNT_MAX;
    exp_q.push_back({word, verdict, m_vcnt[CNT_W-1:0], m_icnt[CNT_W-1:0]});
    bus1.valid_in = verdict;
    bus1.serial_in = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      bus1.serial_in = word[5-i];
      tick();
    end
    bus1.serial_in = 1'b0;
    for (int i = 0; i < check_ticks; i++) tick();
  endtask

  task automatic check_all_zero(input string tag);
    @(negedge clock);
    check({tag, "_state"}, bus1.dbg_state, 0);
    check({tag, "_word"}, word1(), 0);
    check({tag, "_busy"}, bus1.busy, 0);
    check({tag, "_word_ready"}, bus1.word_ready, 0);
    check({tag, "_last_valid"}, bus1.last_valid, 0);
    check({tag, "_valid_count"}, bus1.valid_count, 0);
    check({tag, "_invalid_count"}, bus1.invalid_count, 0);
  endtask

  // Monitor: every word_ready strobe must match the oldest outstanding frame.
  initial begin
    logic [EXP_W-1:0] e;
    forever begin
      @(negedge clock);
      if (bus1.word_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("word_ready_unexpected", bus1.word_ready, 0);
        end else begin
          e = exp_q.pop_front();
          check("mon_word", word1(), e[EXP_W-1 -: 6]);
          @(negedge clock);
          check("mon_word_ready_width", bus1.word_ready, 0);
          check("mon_last_valid", bus1.last_valid, e[2*CNT_W]);
          check("mon_valid_count", bus1.valid_count, e[2*CNT_W-1 -: CNT_W]);
          check("mon_invalid_count", bus1.invalid_count, e[CNT_W-1:0]);
        end
      end
    end
  end

  initial begin
    int busy_seen;
    logic [5:0] w;
    logic v;
    bus1.serial_in = 1'b0;
    bus1.valid_in = 1'b0;
    bus3.serial_in = 1'b0;
    bus3.valid_in = 1'b0;
    do_reset();

    // idle line
    repeat (10) tick();
    check_all_zero("idle");

    // single directed frame
    send_frame(6'b101011, 1'b1, 1);
    @(negedge clock);
    check("frame1_busy", bus1.busy, 0);
    check("frame1_word", word1(), 6'b101011);
    check("frame1_valid_count", bus1.valid_count, 1);
    check("frame1_last_valid", bus1.last_valid, 1);

    // back-to-back frames, then a start bit during CHECK
    do_reset();
    send_frame(6'b000000, 1'b0, 1);
    send_frame(6'b111111, 1'b1, 0);
    bus1.serial_in = 1'b1;
    tick();
    bus1.serial_in = 1'b0;
    busy_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (bus1.busy) busy_seen++;
    end
    check("b2b_misaligned_start_busy", busy_seen, 0);
    check("b2b_valid_count", bus1.valid_count, 1);
    check("b2b_invalid_count", bus1.invalid_count, 1);
    check("b2b_last_valid", bus1.last_valid, 1);
    check("b2b_word", word1(), 6'b111111);

    // reset in the middle of a frame
    send_frame(6'b110011, 1'b1, 1);
    repeat (2) tick();
    bus1.serial_in = 1'b1;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus1.serial_in = 1'b0;
    m_vcnt = 0;
    m_icnt = 0;
    check_all_zero("midreset");
    send_frame(6'b010110, 1'b0, 1);
    @(negedge clock);
    check("post_reset_invalid_count", bus1.invalid_count, 1);
    check("post_reset_word", word1(), 6'b010110);

    // randomized frames with random idle gaps
    for (int n = 0; n < 40; n++) begin
      w = 6'($urandom_range(0, 63));
      v = 1'($urandom_range(0, 1));
      send_frame(w, v, 1);
      repeat ($urandom_range(0, 3)) tick();
    end

    // saturation of valid_count, invalid_count still counting
    for (int n = 0; n < 260; n++) send_frame(6'($urandom_range(0, 63)), 1'b1, 1);
    send_frame(6'b100001, 1'b0, 1);
    repeat (2) tick();
    check("sat_valid_count", bus1.valid_count, CNT_MAX);
    check("sat_invalid_count", bus1.invalid_count, m_icnt);

    // CHECK_WAIT=3 instance: verdict taken only at the end of the third cycle
    do_reset();
    bus3.serial_in = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      bus3.serial_in = (i % 3 == 0) ? 1'b1 : 1'b0;
      tick();
    end
    bus3.serial_in = 1'b1;
    bus3.valid_in = 1'b0;
    @(negedge clock);
    check("cw3_word", word3(), 6'b100100);
    check("cw3_word_ready_c1", bus3.word_ready, 0);
    tick();
    bus3.valid_in = 1'b0;
    @(negedge clock);
    check("cw3_word_ready_c2", bus3.word_ready, 0);
    tick();
    bus3.valid_in = 1'b1;
    @(negedge clock);
    check("cw3_word_ready_c3", bus3.word_ready, 1);
    tick();
    bus3.serial_in = 1'b0;
    bus3.valid_in = 1'b0;
    @(negedge clock);
    check("cw3_word_ready_after", bus3.word_ready, 0);
    check("cw3_last_valid", bus3.last_valid, 1);
    check("cw3_valid_count", bus3.valid_count, 1);
    check("cw3_invalid_count", bus3.invalid_count, 0);
    check("cw3_busy", bus3.busy, 0);

    repeat (5) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/code_word_rx.md
Name: code_word_rx

Overview:
- Upstream feeder for the 6-input code-word validity checker.
- Deserializes framed 6-bit code words from a 1-bit serial line and holds them on a..f, stable for the checker.
- Samples the checker's `valid` result once the checker has settled, then keeps saturating counts of valid and invalid words plus the last verdict.

Parameters:
- CNT_W, 8, width of valid_count and invalid_count.
- CHECK_WAIT, 1, cycles the word is held in CHECK before `valid_in` is sampled (legal range 1..15); covers checker gate delay.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- serial_in  in  1  serial data; 1 in IDLE is a start bit, followed by 6 data bits, a first, f last.
- valid_in  in  1  `valid` output of the checker, driven by the current a..f.
- a, b, c, d, e, f  out  1 each  current code word; registered.
- word_ready  out  1  high for exactly one cycle, the last CHECK cycle; `valid_in` is sampled at the end of that cycle.
- busy  out  1  high in SHIFT and CHECK.
- last_valid  out  1  verdict of the most recent completed word.
- valid_count  out  CNT_W  words judged valid; saturates at all-ones.
- invalid_count  out  CNT_W  words judged invalid; saturates at all-ones.

Behaviour:
- Reset (sampled at a clock edge while reset=1):
  - State goes to IDLE.
  - a..f, last_valid, valid_count, invalid_count, the bit counter and the shift register all go to 0.
  - word_ready=0, busy=0.
  - Reset applied mid-frame or mid-CHECK discards the partial word; no counter changes.
- FSM states: IDLE, SHIFT, CHECK.
- IDLE:
  - If serial_in=1 at edge k, go to SHIFT with bit counter=0.
  - Otherwise stay in IDLE.
- SHIFT:
  - serial_in is shifted in at edges k+1..k+6; the first bit maps to a, the sixth to f.
  - serial_in is not checked for start bits here; a 1 is just data.
  - At edge k+6, all of a..f are loaded in parallel from the assembled bits, then CHECK is entered.
  - a..f never change during SHIFT, so the checker inputs stay glitch-free.
- CHECK:
  - Lasts CHECK_WAIT cycles; serial_in is ignored.
  - word_ready is a Moore output: high only in the final CHECK cycle.
  - At the edge that ends that cycle (edge k+6+CHECK_WAIT):
    - last_valid <= valid_in.
    - If valid_in=1, valid_count increments; otherwise invalid_count increments.
    - A counter at all-ones holds (saturates).
    - State returns to IDLE.
- a..f hold the last word until the next frame's load edge. They are not cleared on return to IDLE.
- Minimum start-bit spacing is 7+CHECK_WAIT cycles (8 at default). A 1 on serial_in during CHECK is not a start bit.
- busy = (state != IDLE).
- No X-propagation: every register has a defined reset value; the default branch of the FSM goes to IDLE.

Test Plan:
- Reset, then serial_in=0 for 10 cycles -> state IDLE; a..f=000000; busy=0; word_ready never asserted; both counts 0.
- Frame 1,1,0,1,0,1,1 (start + data), valid_in=1 -> a..f=1,0,1,0,1,1 from edge k+6; word_ready high one cycle, after edge k+6 until edge k+7; after edge k+7, valid_count=1, last_valid=1, busy=0.
- Two back-to-back frames 8 cycles apart: data 000000 with valid_in=0, then 111111 with valid_in=1 -> invalid_count=1, valid_count=1, last_valid=1; a..f=111111. A start bit issued 7 cycles after the first start is ignored, the frame is misaligned, and the bench checks that its bits are not taken as a start.
- Reset asserted at edge k+3 of a frame -> all outputs 0 next cycle; no counter change; a fresh frame afterwards is received correctly.
- Preload: 255 valid frames, then one more with valid_in=1 -> valid_count stays 8'hFF; invalid_count still increments on a subsequent invalid frame.
- CHECK_WAIT=3 build: a frame with valid_in toggling 0,0,1 across the three CHECK cycles -> word_ready high only in the third cycle; last_valid=1; valid_count=1.
